htu_lookup: RTL and testbench

- Tag-lookup stage directly upstream of the HTU PLRU replacer.
- Accepts one lookup request at a time and reads the per-set meta array, which has 1-cycle read latency.
- Compares tags across all ways. A hit touches the hit way in the replacer. A miss presents the set's meta to the replacer, takes its registered victim way, touches that way, and reports the victim's writeback need.
- Returns a single response per request on a valid/ready handshake.

---
 rtl/htu_lookup.sv | 160 ++++++++++++++++
 tb/tb_htu_lookup.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/htu_lookup.sv
// Tag-lookup stage feeding the HTU PLRU replacer: reads set meta, compares tags,
// touches the hit or victim way and returns one response per request.
module htu_lookup #(
  parameter int WAY_NUM   = 4,
  parameter int WAY_IDX_W = 2,
  parameter int SET_W     = 6,
  parameter int TAG_W     = 20,
  parameter int META_W    = TAG_W + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [SET_W-1:0]           req_set,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       meta_rd_en,
  output logic [SET_W-1:0]           meta_rd_set,
  input  logic [WAY_NUM*META_W-1:0]  meta_rd_data,
  output logic [SET_W-1:0]           replace_set,
  output logic [WAY_NUM*META_W-1:0]  replace_meta,
  input  logic [WAY_IDX_W-1:0]       replace_way,
  output logic                       replace_access_valid,
  output logic [SET_W-1:0]           replace_access_set,
  output logic [WAY_IDX_W-1:0]       replace_access_way,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_hit,
  output logic [WAY_IDX_W-1:0]       resp_way,
  output logic                       resp_evict,
  output logic [TAG_W-1:0]           resp_evict_tag,
  output logic                       multi_hit_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MISS_WAIT = 3'd2,
    S_MISS_SEL  = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t                      state_q;
  logic [SET_W-1:0]            set_q;
  logic [TAG_W-1:0]            tag_q;
  logic [WAY_NUM*META_W-1:0]   meta_q;
  logic                        resp_valid_q;
  logic                        resp_hit_q;
  logic [WAY_IDX_W-1:0]        resp_way_q;
  logic                        resp_evict_q;
  logic [TAG_W-1:0]            resp_evict_tag_q;
  logic                        multi_hit_err_q;

  logic [WAY_NUM-1:0]          hit_vec;
  logic                        hit_any;
  logic                        multi_hit;
  logic [WAY_IDX_W-1:0]        hit_way;
  logic [META_W-1:0]           victim_meta;
  logic                        victim_evict;

  // Tag compare works on the raw array output: it is only valid in LOOKUP.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      hit_vec[i] = meta_rd_data[i*META_W + META_W - 1] &&
                   (meta_rd_data[i*META_W +: TAG_W] == tag_q);
    end
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_IDX_W'(i);
    end
  end

  assign hit_any   = |hit_vec;
  assign multi_hit = (hit_vec & (hit_vec - WAY_NUM'(1))) != '0;

  always_comb begin
    victim_meta = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      if (replace_way == WAY_IDX_W'(i)) victim_meta = meta_q[i*META_W +: META_W];
    end
  end

  assign victim_evict = victim_meta[META_W-1] & victim_meta[META_W-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      set_q            <= '0;
      tag_q            <= '0;
      meta_q           <= '0;
      resp_valid_q     <= 1'b0;
      resp_hit_q       <= 1'b0;
      resp_way_q       <= '0;
      resp_evict_q     <= 1'b0;
      resp_evict_tag_q <= '0;
      multi_hit_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            set_q   <= req_set;
            tag_q   <= req_tag;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          meta_q <= meta_rd_data;
          if (hit_any) begin
            resp_valid_q     <= 1'b1;
            resp_hit_q       <= 1'b1;
            resp_way_q       <= hit_way;
            resp_evict_q     <= 1'b0;
            resp_evict_tag_q <= '0;
            if (multi_hit) multi_hit_err_q <= 1'b1;
            state_q <= S_RESP;
          end else begin
            state_q <= S_MISS_WAIT;
          end
        end
        // Replacer registers its victim from meta_q during this cycle.
        S_MISS_WAIT: state_q <= S_MISS_SEL;
        S_MISS_SEL: begin
          resp_valid_q     <= 1'b1;
          resp_hit_q       <= 1'b0;
          resp_way_q       <= replace_way;
          resp_evict_q     <= victim_evict;
          resp_evict_tag_q <= victim_evict ? victim_meta[TAG_W-1:0] : '0;
          state_q          <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign meta_rd_en  = req_ready & req_valid & ~rst;
  assign meta_rd_set = req_set;

  assign replace_set  = set_q;
  assign replace_meta = meta_q;

  assign replace_access_valid = ~rst & (((state_q == S_LOOKUP) & hit_any) |
                                        (state_q == S_MISS_SEL));
  assign replace_access_set   = set_q;
  assign replace_access_way   = (state_q == S_MISS_SEL) ? replace_way : hit_way;

  assign resp_valid     = resp_valid_q;
  assign resp_hit       = resp_hit_q;
  assign resp_way       = resp_way_q;
  assign resp_evict     = resp_evict_q;
  assign resp_evict_tag = resp_evict_tag_q;
  assign multi_hit_err  = multi_hit_err_q;

endmodule

// File: tb/tb_htu_lookup.sv
// Scoreboard bench for htu_lookup with behavioural meta array and replacer models.
module tb_htu_lookup;

  localparam int WAY_NUM = 4;
  localparam int WIW     = 2;
  localparam int SET_W   = 6;
  localparam int TAG_W   = 20;
  localparam int META_W  = TAG_W + 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      req_valid;
  logic                      req_ready;
  logic [SET_W-1:0]          req_set;
  logic [TAG_W-1:0]          req_tag;
  logic                      meta_rd_en;
  logic [SET_W-1:0]          meta_rd_set;
  logic [WAY_NUM*META_W-1:0] meta_rd_data;
  logic [SET_W-1:0]          replace_set;
  logic [WAY_NUM*META_W-1:0] replace_meta;
  logic [WIW-1:0]            replace_way;
  logic                      replace_access_valid;
  logic [SET_W-1:0]          replace_access_set;
  logic [WIW-1:0]            replace_access_way;
  logic                      resp_valid;
  logic                      resp_ready;
  logic                      resp_hit;
  logic [WIW-1:0]            resp_way;
  logic                      resp_evict;
  logic [TAG_W-1:0]          resp_evict_tag;
  logic                      multi_hit_err;

  htu_lookup #(.WAY_NUM(WAY_NUM), .WAY_IDX_W(WIW), .SET_W(SET_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
    .meta_rd_en(meta_rd_en), .meta_rd_set(meta_rd_set), .meta_rd_data(meta_rd_data),
    .replace_set(replace_set), .replace_meta(replace_meta), .replace_way(replace_way),
    .replace_access_valid(replace_access_valid), .replace_access_set(replace_access_set),
    .replace_access_way(replace_access_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_way(resp_way), .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
    .multi_hit_err(multi_hit_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Meta array model: 1-cycle registered read.
  logic [WAY_NUM*META_W-1:0] meta_mem [64];
  always @(posedge clk) if (meta_rd_en) meta_rd_data <= meta_mem[meta_rd_set];

  // Replacer model: lowest invalid way, else a bench-chosen way; registered.
  logic [WIW-1:0] repl_full_way;
  function automatic logic [WIW-1:0] pick_victim(input logic [WAY_NUM*META_W-1:0] m,
                                                 input logic [WIW-1:0] full_way);
    for (int i = 0; i < WAY_NUM; i++)
      if (!m[i*META_W + META_W - 1]) return WIW'(i);
    return full_way;
  endfunction
  always @(posedge clk) replace_way <= pick_victim(replace_meta, repl_full_way);

  task automatic set_way(input int s, input int w, input bit v, input bit d, input logic [TAG_W-1:0] t);
    logic [WAY_NUM*META_W-1:0] row;
    row = meta_mem[s];
    row[w*META_W +: META_W] = {v, d, t};
    meta_mem[s] = row;
  endtask

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic             hit;
    logic [WIW-1:0]   way;
    logic             ev;
    logic [TAG_W-1:0] etag;
    int               cyc;
  } resp_t;
  typedef struct {
    logic [SET_W-1:0] set;
    logic [WIW-1:0]   way;
    int               cyc;
  } touch_t;

  resp_t  resp_q[$];
  touch_t touch_q[$];
  bit     resp_seen = 1'b0;

  // Monitor: compares touches and responses against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (replace_access_valid) begin
        if (touch_q.size() == 0) begin
          chk("unexpected_touch", 32'(replace_access_way), 32'hFFFF_FFFF);
        end else begin
          touch_t t;
          t = touch_q.pop_front();
          chk("touch_set", 32'(replace_access_set), 32'(t.set));
          chk("touch_way", 32'(replace_access_way), 32'(t.way));
          chk("touch_cycle", 32'(cyc), 32'(t.cyc));
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          resp_t r;
          r = resp_q[0];
          if (!resp_seen) begin
            chk("resp_cycle", 32'(cyc), 32'(r.cyc));
            resp_seen = 1'b1;
          end
          chk("resp_hit", 32'(resp_hit), 32'(r.hit));
          chk("resp_way", 32'(resp_way), 32'(r.way));
          chk("resp_evict", 32'(resp_evict), 32'(r.ev));
          chk("resp_evict_tag", 32'(resp_evict_tag), 32'(r.etag));
          if (resp_ready) begin
            void'(resp_q.pop_front());
            resp_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    if (!req_ready) chk("wait_req_ready_timeout", 32'(req_ready), 32'h1);
  endtask

  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || touch_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    if (resp_q.size() != 0) chk("drain_timeout", 32'(resp_q.size()), 32'h0);
  endtask

  // Issue one request; returns at cycle c0+1 with req_valid dropped.
  task automatic issue(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                       input logic hit, input logic [WIW-1:0] way,
                       input logic ev, input logic [TAG_W-1:0] etag, output int c0);
    resp_t  r;
    touch_t tc;
    wait_idle();
    req_valid = 1'b1;
    req_set   = s;
    req_tag   = t;
    c0        = cyc;
    tc.set = s; tc.way = way; tc.cyc = c0 + (hit ? 1 : 3);
    r.hit = hit; r.way = way; r.ev = ev; r.etag = etag; r.cyc = c0 + (hit ? 2 : 4);
    touch_q.push_back(tc);
    resp_q.push_back(r);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int s = 0; s < 64; s++) meta_mem[s] = '0;
    // set 5: single valid match in way 2
    set_way(5, 0, 1, 0, 20'h00124);
    set_way(5, 1, 0, 1, 20'h00123);
    set_way(5, 2, 1, 0, 20'h00123);
    set_way(5, 3, 1, 1, 20'h00999);
    // set 7: all invalid, way 0 carries the requested tag and a dirty bit
    set_way(7, 0, 0, 1, 20'h00ABC);
    set_way(7, 2, 0, 0, 20'h00ABC);
    // set 3: full
    set_way(3, 0, 1, 0, 20'h00011);
    set_way(3, 1, 1, 1, 20'h00055);
    set_way(3, 2, 1, 1, 20'h00022);
    set_way(3, 3, 1, 0, 20'h00033);
    // set 10: duplicate valid tag in ways 1 and 3
    set_way(10, 0, 0, 0, 20'h00010);
    set_way(10, 1, 1, 0, 20'h00010);
    set_way(10, 2, 1, 0, 20'h00011);
    set_way(10, 3, 1, 1, 20'h00010);

    repl_full_way = 2'd0;
    rst = 1'b1; req_valid = 1'b0; req_set = '0; req_tag = '0; resp_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_resp_valid", 32'(resp_valid), 32'h0);
    chk("reset_touch", 32'(replace_access_valid), 32'h0);
    chk("reset_multi_hit_err", 32'(multi_hit_err), 32'h0);
    chk("reset_meta_rd_en", 32'(meta_rd_en), 32'h0);

    // hit
    issue(6'd5, 20'h00123, 1'b1, 2'd2, 1'b0, 20'h0, c0);
    drain();
    // miss, all-invalid set
    issue(6'd7, 20'h00ABC, 1'b0, 2'd0, 1'b0, 20'h0, c0);
    drain();
    // miss, dirty victim
    repl_full_way = 2'd1;
    issue(6'd3, 20'h00099, 1'b0, 2'd1, 1'b1, 20'h00055, c0);
    drain();
    // miss, clean valid victim
    repl_full_way = 2'd3;
    issue(6'd3, 20'h00099, 1'b0, 2'd3, 1'b0, 20'h0, c0);
    drain();
    chk("no_multi_hit_yet", 32'(multi_hit_err), 32'h0);

    // back-pressure on a hit: ready low in cycles 2..6, handshake in cycle 7
    resp_ready = 1'b0;
    issue(6'd5, 20'h00123, 1'b1, 2'd2, 1'b0, 20'h0, c0);
    for (int k = 1; k <= 6; k++) begin
      chk("stall_req_ready", 32'(req_ready), 32'h0);
      step();
    end
    chk("stall_cycle", 32'(cyc), 32'(c0 + 7));
    chk("stall_resp_valid", 32'(resp_valid), 32'h1);
    resp_ready = 1'b1;
    step();
    chk("post_hs_req_ready", 32'(req_ready), 32'h1);
    chk("post_hs_resp_valid", 32'(resp_valid), 32'h0);

    // multi-hit: lowest way wins, error is sticky
    issue(6'd10, 20'h00010, 1'b1, 2'd1, 1'b0, 20'h0, c0);
    drain();
    chk("multi_hit_err_set", 32'(multi_hit_err), 32'h1);
    issue(6'd5, 20'h00123, 1'b1, 2'd2, 1'b0, 20'h0, c0);
    drain();
    chk("multi_hit_err_sticky", 32'(multi_hit_err), 32'h1);

    // reset while in MISS_WAIT abandons the request
    wait_idle();
    req_valid = 1'b1; req_set = 6'd9; req_tag = 20'h00777;
    c0 = cyc;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_req_ready", 32'(req_ready), 32'h1);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_mid_multi_hit_err", 32'(multi_hit_err), 32'h0);
    step();
    chk("rst_mid_no_late_resp", 32'(resp_valid), 32'h0);
    repeat (3) step();
    chk("rst_mid_still_idle", 32'(req_ready), 32'h1);

    // fresh request after reset
    issue(6'd7, 20'h00ABC, 1'b0, 2'd0, 1'b0, 20'h0, c0);
    drain();

    chk("touch_queue_empty", 32'(touch_q.size()), 32'h0);
    chk("resp_queue_empty", 32'(resp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
